// File: rtl/alu_cmd_issuer.sv
// Command FIFO + issue FSM in front of a combinational ALU, with a registered result stage.
// Optional macro ALU_CMD_BYPASS_EN: commands arriving while idle and empty skip the FIFO.
module alu_cmd_issuer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = 4,
  parameter int unsigned RES_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [DATA_W-1:0]        cmd_a,
  input  logic [DATA_W-1:0]        cmd_b,
  input  logic [SEL_W-1:0]         cmd_sel,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [SEL_W-1:0]         alu_sel,
  input  logic [RES_W-1:0]         alu_out,
  input  logic                     alu_carry,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [RES_W-1:0]         res_data,
  output logic                     res_carry,
  output logic                     res_zero,
  output logic [SEL_W-1:0]         res_tag,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = PW + 1;
  localparam int unsigned ENT_W = 2 * DATA_W + SEL_W;

  typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

  state_t            state;
  logic [ENT_W-1:0]  mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              push;
  logic              bypass;
  logic              push_fifo;
  logic              do_pop;
  logic [DATA_W-1:0] head_a;
  logic [DATA_W-1:0] head_b;
  logic [SEL_W-1:0]  head_sel;

  // No lookahead: a full FIFO refuses even when the issuer pops the same cycle.
  assign cmd_ready  = (count < CW'(DEPTH));
  assign fifo_count = count;
  assign push       = cmd_valid && cmd_ready;

`ifdef ALU_CMD_BYPASS_EN
  assign bypass = push && (state == IDLE) && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign push_fifo = push && !bypass;
  assign do_pop    = (count != '0) && ((state == IDLE) || ((state == HOLD) && res_ready));

  assign {head_a, head_b, head_sel} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_fifo) begin
      mem[wr_ptr] <= {cmd_a, cmd_b, cmd_sel};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_zero  <= 1'b0;
      res_tag   <= '0;
    end else begin
      if (push_fifo) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_fifo, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          if (do_pop) begin
            alu_a   <= head_a;
            alu_b   <= head_b;
            alu_sel <= head_sel;
            state   <= DRIVE;
          end else if (bypass) begin
            alu_a   <= cmd_a;
            alu_b   <= cmd_b;
            alu_sel <= cmd_sel;
            state   <= DRIVE;
          end
        end
        DRIVE: begin
          res_data  <= alu_out;
          res_carry <= alu_carry;
          res_zero  <= (alu_out == '0);
          res_tag   <= alu_sel;
          res_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (do_pop) begin
              alu_a   <= head_a;
              alu_b   <= head_b;
              alu_sel <= head_sel;
              state   <= DRIVE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer with a stub ALU: out = {a,b}, carry = ^sel.
module tb_alu_cmd_issuer;

  localparam int unsigned DEPTH = 4;
`ifdef ALU_CMD_BYPASS_EN
  localparam int unsigned LAT = 1;
`else
  localparam int unsigned LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [3:0]  cmd_sel;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_sel;
  logic [15:0] alu_out;
  logic        alu_carry;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_carry;
  logic        res_zero;
  logic [3:0]  res_tag;
  logic [2:0]  fifo_count;

  typedef struct packed {
    logic [15:0] data;
    logic        carry;
    logic        zero;
    logic [3:0]  tag;
  } res_t;

  res_t        exp_q [$];
  int unsigned tests;
  int unsigned failed;
  int unsigned max_count;

  alu_cmd_issuer #(.DEPTH(DEPTH), .DATA_W(8), .SEL_W(4), .RES_W(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry), .res_zero(res_zero), .res_tag(res_tag),
    .fifo_count(fifo_count)
  );

  assign alu_out   = {alu_a, alu_b};
  assign alu_carry = ^alu_sel;

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    res_t r;
    int unsigned v;
    v       = int'(a) * 256 + int'(b);
    r.data  = 16'(v);
    r.carry = ($countones(s) % 2) == 1;
    r.zero  = (v == 0);
    r.tag   = s;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    int unsigned n;
    logic ok;
    n = 0;
    cmd_a = a; cmd_b = b; cmd_sel = s; cmd_valid = 1'b1;
    do begin
      ok = cmd_ready;
      tick();
      n++;
    end while (!ok && n < 100);
    if (!ok) chk("push_timeout", 32'(ok), 32'(1));
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    while ((exp_q.size() != 0 || res_valid || fifo_count != 0) && n < 300) begin
      tick();
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'(0));
    chk("drain_count", 32'(fifo_count), 32'(0));
  endtask

  initial begin
    int unsigned lat;
    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0; res_ready = 1'b0;
    tests = 0; failed = 0; max_count = 0;

    // Monitor: handshakes are sampled mid-cycle, so they describe the upcoming edge.
    fork
      begin
        logic prev_hs;
        logic prev_hold;
        res_t held;
        res_t act;
        prev_hs = 1'b0; prev_hold = 1'b0; held = '0;
        forever begin
          @(negedge clk);
          if (rst) begin
            exp_q.delete();
            prev_hs = 1'b0;
            prev_hold = 1'b0;
          end else begin
            act = {res_data, res_carry, res_zero, res_tag};
            chk("cmd_ready_vs_count", 32'(cmd_ready), 32'(fifo_count < DEPTH));
            if (prev_hs) chk("valid_gap_after_delivery", 32'(res_valid), 32'(0));
            if (prev_hold) begin
              chk("hold_valid", 32'(res_valid), 32'(1));
              chk("hold_stable", 32'(act), 32'(held));
            end
            if (fifo_count > max_count) max_count = fifo_count;
            if (cmd_valid && cmd_ready) exp_q.push_back(model(cmd_a, cmd_b, cmd_sel));
            if (res_valid && res_ready) begin
              if (exp_q.size() == 0) chk("unexpected_result", 32'(act), 32'(0) - 32'(1));
              else chk("result{data,carry,zero,tag}", 32'(act), 32'(exp_q.pop_front()));
            end
            prev_hs   = res_valid && res_ready;
            prev_hold = res_valid && !res_ready;
            held      = act;
          end
        end
      end
    join_none

    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_res_valid", 32'(res_valid), 32'(0));
    chk("rst_fifo_count", 32'(fifo_count), 32'(0));
    chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    chk("rst_alu", 32'({alu_a, alu_b, alu_sel}), 32'(0));
    chk("rst_res", 32'({res_data, res_carry, res_zero, res_tag}), 32'(0));

    // Single command latency and one-cycle pulse
    res_ready = 1'b1;
    push_cmd(8'hAA, 8'h55, 4'h3);
    lat = 0;
    while (!res_valid && lat < 20) begin tick(); lat++; end
    chk("latency", 32'(lat), 32'(LAT));
    chk("first_data", 32'(res_data), 32'(16'hAA55));
    tick();
    chk("valid_pulse", 32'(res_valid), 32'(0));
    drain();

    // 16 back-to-back commands
    max_count = 0;
    for (int i = 0; i < 16; i++) push_cmd(8'h00, 8'h00, 4'(i));
    drain();
    chk("fifo_reached_full", 32'(max_count), 32'(DEPTH));

    // Backpressure: one held result plus a full FIFO
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(8'(8'h10 + i), 8'(8'h20 + i), 4'(i + 5));
    chk("bp_count_full", 32'(fifo_count), 32'(4));
    chk("bp_cmd_ready", 32'(cmd_ready), 32'(0));
    chk("bp_res_valid", 32'(res_valid), 32'(1));
    repeat (3) tick();
    chk("bp_tag_first", 32'(res_tag), 32'(5));
    // Push offered at full on the same edge the issuer pops
    cmd_a = 8'h77; cmd_b = 8'h88; cmd_sel = 4'hC; cmd_valid = 1'b1; res_ready = 1'b1;
    chk("full_pop_ready", 32'(cmd_ready), 32'(0));
    tick();
    chk("full_pop_count", 32'(fifo_count), 32'(3));
    begin
      int unsigned n;
      logic ok;
      n = 0;
      do begin ok = cmd_ready; tick(); n++; end while (!ok && n < 50);
      if (!ok) chk("late_push_timeout", 32'(ok), 32'(1));
    end
    cmd_valid = 1'b0;
    drain();

    // Reset while holding with three buffered
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd(8'(8'h30 + i), 8'(8'h40 + i), 4'(i + 1));
    chk("pre_rst_count", 32'(fifo_count), 32'(3));
    chk("pre_rst_valid", 32'(res_valid), 32'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(res_valid), 32'(0));
    chk("mid_rst_count", 32'(fifo_count), 32'(0));
    chk("mid_rst_alu", 32'({alu_a, alu_b, alu_sel}), 32'(0));
    res_ready = 1'b1;
    push_cmd(8'h5A, 8'hA5, 4'h9);
    drain();

    // Zero-flag boundaries
    push_cmd(8'h00, 8'h01, 4'h2);
    push_cmd(8'h00, 8'h00, 4'hF);
    drain();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      res_ready = ($urandom_range(0, 3) != 0);
      cmd_a     = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      cmd_b     = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      cmd_sel   = 4'($urandom);
      tick();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
